muldiv_ctrl: RTL and testbench

Iterative multiply/divide controller serving MULT, MULTU, DIV and DIVU from the execute stage. It accepts one operation per handshake and sequences a shared 32-step shift/subtract datapath. It delivers a 64-bit {hi, lo} result to the HI/LO write path and holds `busy` so the pipeline stalls dependent MFHI/MFLO. It sits beside the ALU in execute, driven by decoded ops carrying `ctl.hiwrite`/`ctl.lowrite`.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_ctrl_div_step.sv | 22 ++
 rtl/muldiv_ctrl.sv | 176 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide controller: state encoding,
// decoded op codes, result layout and a magnitude helper.
package muldiv_pkg;

  localparam int unsigned MULDIV_STEPS = 32;

  typedef logic [31:0] word_t;

  typedef enum logic [5:0] {
    OP_MULT  = 6'h18,
    OP_MULTU = 6'h19,
    OP_DIV   = 6'h1a,
    OP_DIVU  = 6'h1b
  } decoded_op_t;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } muldiv_state_t;

  typedef struct packed {
    word_t hi;
    word_t lo;
  } muldiv_result_t;

  function automatic word_t abs_w(input word_t v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference when it does not go negative.
module div_step
  import muldiv_pkg::*;
(
  input  logic [63:0] acc_i,
  input  word_t       divisor_i,
  output word_t       rem_o,
  output logic        q_o
);

  logic [32:0] trial;
  logic [32:0] diff;

  always_comb begin
    trial = acc_i[63:31];
    diff  = trial - {1'b0, divisor_i};
    q_o   = ~diff[32];
    rem_o = q_o ? diff[31:0] : trial[31:0];
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU controller delivering {hi, lo}.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply (divide unchanged).
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  muldiv_state_t  state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [63:0]    acc_q, acc_d;
  word_t          opnd_q, opnd_d;
  logic [5:0]     op_q, op_d;
  logic           neg_lo_q, neg_lo_d;
  logic           neg_hi_q, neg_hi_d;
  muldiv_result_t res_q, res_d;
  logic           out_valid_q, out_valid_d;

  logic           is_mul, is_div, is_signed, accept;
  logic [63:0]    prod_neg;
  muldiv_result_t fixed;
  word_t          rem_next;
  logic           q_bit;
`ifdef MULDIV_FAST_MUL_EN
  logic signed [65:0] fast_prod;
`else
  logic [32:0]    mul_sum;
  logic [63:0]    mul_next;
`endif

  assign in_ready  = (state_q == IDLE) || (state_q == DONE);
  assign busy      = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
  assign out_valid = out_valid_q & ~flush;
  assign hi        = res_q.hi;
  assign lo        = res_q.lo;

  // opnd_q holds the multiplicand for MUL and the divisor for DIV.
  div_step u_div_step (
    .acc_i     (acc_q),
    .divisor_i (opnd_q),
    .rem_o     (rem_next),
    .q_o       (q_bit)
  );

  always_comb begin
    is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    accept    = in_valid && in_ready && !flush && (is_mul || is_div);

    prod_neg = 64'd0 - acc_q;
    if ((op_q == OP_MULT) || (op_q == OP_MULTU)) begin
      fixed = neg_lo_q ? prod_neg : acc_q;
    end else begin
      fixed.lo = neg_lo_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
      fixed.hi = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    end

`ifdef MULDIV_FAST_MUL_EN
    fast_prod = $signed({(op_q == OP_MULT) && opnd_q[31], opnd_q})
              * $signed({(op_q == OP_MULT) && acc_q[31], acc_q[31:0]});
`else
    // Shift-add: product grows in the top half while the multiplier drains out the bottom.
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
`endif

    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    op_d        = op_q;
    neg_lo_d    = neg_lo_q;
    neg_hi_d    = neg_hi_q;
    res_d       = res_q;
    out_valid_d = 1'b0;

    unique case (state_q)
      MUL: begin
`ifdef MULDIV_FAST_MUL_EN
        res_d       = fast_prod[63:0];
        out_valid_d = 1'b1;
        state_d     = DONE;
`else
        acc_d = mul_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(MULDIV_STEPS - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end
`endif
      end
      DIV: begin
        acc_d = {rem_next, acc_q[30:0], q_bit};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(MULDIV_STEPS - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
      FIX: begin
        res_d       = fixed;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase

    if (accept) begin
      op_d     = op;
      cnt_d    = '0;
      neg_lo_d = is_signed && (a[31] ^ b[31]);
      neg_hi_d = is_signed && is_div && a[31];
      if (is_mul) begin
        state_d = MUL;
`ifdef MULDIV_FAST_MUL_EN
        opnd_d  = a;
        acc_d   = {32'd0, b};
`else
        opnd_d  = is_signed ? abs_w(a) : a;
        acc_d   = {32'd0, is_signed ? abs_w(b) : b};
`endif
      end else begin
        state_d = DIV;
        opnd_d  = is_signed ? abs_w(b) : b;
        acc_d   = {32'd0, is_signed ? abs_w(a) : a};
      end
    end

    if (flush) begin
      state_d     = IDLE;
      cnt_d       = '0;
      res_d       = res_q;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      op_q        <= '0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      op_q        <= op_d;
      neg_lo_q    <= neg_lo_d;
      neg_hi_q    <= neg_hi_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed table, random ops against an
// arithmetic reference, and flush/reset/invalid-op sequences.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, in_valid, flush;
  logic [5:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        in_ready, out_valid, busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] last_res;

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
    .hi(hi), .lo(lo), .busy(busy)
  );

  typedef struct {
    logic [5:0]  vop;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; signed division truncates toward zero.
  function automatic logic [63:0] model(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == OP_MULT) return 64'(sx * sy);
    if (o == OP_MULTU) return {32'd0, x} * {32'd0, y};
    if (o == OP_DIVU) return (y == 32'd0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
    if (y == 32'd0) return {x, (x[31] ? 32'd1 : 32'hFFFFFFFF)};
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int latency(input logic [5:0] o);
`ifdef MULDIV_FAST_MUL_EN
    if (o == OP_MULT || o == OP_MULTU) return 2;
`endif
    return 34;
  endfunction

  task automatic run_op(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                        input string name, input logic [63:0] exp);
    int  k, w;
    bit  got, busy_ok;
    w = 0;
    while (in_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 100) check({name, " ready-wait"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    got = 1'b0; busy_ok = 1'b1; k = 1;
    while (k <= 40 && !got) begin
      if (out_valid === 1'b1) got = 1'b1;
      else begin
        if (busy !== 1'b1 || in_ready !== 1'b0) busy_ok = 1'b0;
        @(posedge clk); #1; k++;
      end
    end
    check({name, " latency"}, 64'(k), 64'(latency(o)));
    check({name, " result"}, {hi, lo}, exp);
    check({name, " busy window"}, 64'(busy_ok), 64'd1);
    check({name, " done flags"}, {62'd0, busy, in_ready}, 64'd1);
    last_res = exp;
  endtask

  vec_t vecs[8];

  initial begin
    bit ok;
    logic [5:0]  ro;
    logic [31:0] ra, rb;

    vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4] = '{OP_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    vecs[5] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'h00000001};

    resetn = 1'b0; in_valid = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {hi, lo}, 64'd0);
    check("reset flags", {61'd0, in_ready, busy, out_valid}, 64'b100);
    resetn = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op(vecs[i].vop, vecs[i].va, vecs[i].vb, $sformatf("vec%0d", i), {vecs[i].ehi, vecs[i].elo});

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: ro = OP_MULT;
        1: ro = OP_MULTU;
        2: ro = OP_DIV;
        default: ro = OP_DIVU;
      endcase
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h80000000;
        2: rb = 32'hFFFFFFFF;
        3: rb = $urandom_range(1, 20);
        default: ;
      endcase
      run_op(ro, ra, rb, $sformatf("rand%0d", i), model(ro, ra, rb));
    end

    // Invalid op: never accepted, never answers.
    @(posedge clk); #1;
    ok = 1'b1;
    in_valid = 1'b1; op = 6'h20;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) ok = 1'b0;
    end
    in_valid = 1'b0;
    check("invalid op ignored", 64'(ok), 64'd1);

    // Flush wins over an accept in the same cycle.
    in_valid = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush beats accept", {62'd0, busy, in_ready}, 64'b01);

    // DIV aborted by flush at T+10, then DIVU 100/7 issued at T+11.
    in_valid = 1'b1; op = OP_DIV; a = 32'hFFFF0000; b = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (out_valid !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      @(posedge clk); #1;
    end
    check("busy before flush", 64'(ok), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush -> idle", {61'd0, busy, in_ready, out_valid}, 64'b010);
    check("flush keeps result", {hi, lo}, last_res);
    run_op(OP_DIVU, 32'd100, 32'd7, "post-flush divu", {32'd2, 32'd14});

    // Asynchronous reset mid-operation discards the work.
    in_valid = 1'b1; op = OP_MULTU; a = 32'd1234; b = 32'd5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    #2;
    check("async reset mid-op", {hi, lo, 61'd0, busy, in_ready, out_valid}, {64'd0, 64'b010});
    @(posedge clk); #1;
    resetn = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    check("no result after reset", 64'(ok), 64'd1);
    run_op(OP_MULT, 32'hFFFFFFFF, 32'h7FFFFFFF, "post-reset mult", model(OP_MULT, 32'hFFFFFFFF, 32'h7FFFFFFF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
